decode_execute_register: RTL and testbench

- Pipeline register between the Decode (ID) and Execute (EX) stages of the 16-bit CPU.
- Captures the decoded control bits and the two source operands on each rising clock edge and presents them to EX one cycle later.
- Supports hold (stall) and bubble insertion (flush) for hazard handling.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_reg.sv | 24 ++
 rtl/decode_execute_register.sv | 94 +++++++++
 tb/tb_decode_execute_register.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU pipeline stages.
package cpu_pkg;

   localparam int DATA_W  = 16;
   localparam int ALUOP_W = 3;

   // Encodings decoded by the EX stage ALU
   typedef enum logic [ALUOP_W-1:0] {
      ALU_NOP = 3'b000,
      ALU_ADD = 3'b001,
      ALU_SUB = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101,
      ALU_SHL = 3'b110,
      ALU_SHR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic               wbs;
      logic               mm;
      logic [ALUOP_W-1:0] alu_op;
      logic               wm;
      logic               am;
      logic               ni;
      logic               wce;
      logic               wme1;
      logic               wme2;
   } idex_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic stage register: sync active-low reset, flush to zero, load enable.
// Latency: one clock edge from d to q.
// Backpressure: en=0 holds q; flush and reset both override en.
module pipe_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= '0;
      else if (flush)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/decode_execute_register.sv
// ID/EX pipeline register: carries decoded control bits and both source operands.
// Latency: one clock edge; every output is a flop.
// Backpressure: stall holds contents; flush loads a bubble and wins over stall.
module decode_execute_register
   import cpu_pkg::*;
#(
   parameter int DATA_W  = cpu_pkg::DATA_W,
   parameter int ALUOP_W = cpu_pkg::ALUOP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               wbs_in,
   input  logic               mm_in,
   input  logic [ALUOP_W-1:0] ALUop_in,
   input  logic               wm_in,
   input  logic               am_in,
   input  logic               ni_in,
   input  logic               wce_in,
   input  logic               wme1_in,
   input  logic               wme2_in,
   input  logic [DATA_W-1:0]  srcA_in,
   input  logic [DATA_W-1:0]  srcB_in,
   output logic               wbs_out,
   output logic               mm_out,
   output logic [ALUOP_W-1:0] ALUop_out,
   output logic               wm_out,
   output logic               am_out,
   output logic               ni_out,
   output logic               wce_out,
   output logic               wme1_out,
   output logic               wme2_out,
   output logic [DATA_W-1:0]  srcA_out,
   output logic [DATA_W-1:0]  srcB_out
);

   idex_ctrl_t ctrl_d;
   idex_ctrl_t ctrl_q;
   logic       load_en;

   assign load_en = !stall;

   // Control combinations are stored as given; legality is EX's concern
   assign ctrl_d = '{
      wbs:    wbs_in,
      mm:     mm_in,
      alu_op: ALUop_in,
      wm:     wm_in,
      am:     am_in,
      ni:     ni_in,
      wce:    wce_in,
      wme1:   wme1_in,
      wme2:   wme2_in
   };

   pipe_reg #(.W($bits(idex_ctrl_t))) u_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .en    (load_en),
      .d     (ctrl_d),
      .q     (ctrl_q)
   );

   pipe_reg #(.W(DATA_W)) u_src_a (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .en    (load_en),
      .d     (srcA_in),
      .q     (srcA_out)
   );

   pipe_reg #(.W(DATA_W)) u_src_b (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .en    (load_en),
      .d     (srcB_in),
      .q     (srcB_out)
   );

   assign wbs_out   = ctrl_q.wbs;
   assign mm_out    = ctrl_q.mm;
   assign ALUop_out = ctrl_q.alu_op;
   assign wm_out    = ctrl_q.wm;
   assign am_out    = ctrl_q.am;
   assign ni_out    = ctrl_q.ni;
   assign wce_out   = ctrl_q.wce;
   assign wme1_out  = ctrl_q.wme1;
   assign wme2_out  = ctrl_q.wme2;

endmodule

// File: tb/tb_decode_execute_register.sv
// Directed bench for the ID/EX register: reset, load, stall, flush and reset priority.
module tb_decode_execute_register;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush;
   logic        wbs_in, mm_in, wm_in, am_in, ni_in, wce_in, wme1_in, wme2_in;
   logic [2:0]  ALUop_in;
   logic [15:0] srcA_in, srcB_in;
   logic        wbs_out, mm_out, wm_out, am_out, ni_out, wce_out, wme1_out, wme2_out;
   logic [2:0]  ALUop_out;
   logic [15:0] srcA_out, srcB_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Bit layout: wbs mm ALUop[2:0] wm am ni wce wme1 wme2 srcA[15:0] srcB[15:0]
   localparam logic [42:0] V_ZERO = '0;
   localparam logic [42:0] V1 = {1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 3'b000, 16'h0006, 16'h0007};
   localparam logic [42:0] V2 = {1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0001, 16'h0005};
   localparam logic [42:0] V3 = {1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 16'hFFFF, 16'h1234};

   logic [42:0] obs;
   assign obs = {wbs_out, mm_out, ALUop_out, wm_out, am_out, ni_out,
                 wce_out, wme1_out, wme2_out, srcA_out, srcB_out};

   always #5 clk = ~clk;

   decode_execute_register dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .flush     (flush),
      .wbs_in    (wbs_in),
      .mm_in     (mm_in),
      .ALUop_in  (ALUop_in),
      .wm_in     (wm_in),
      .am_in     (am_in),
      .ni_in     (ni_in),
      .wce_in    (wce_in),
      .wme1_in   (wme1_in),
      .wme2_in   (wme2_in),
      .srcA_in   (srcA_in),
      .srcB_in   (srcB_in),
      .wbs_out   (wbs_out),
      .mm_out    (mm_out),
      .ALUop_out (ALUop_out),
      .wm_out    (wm_out),
      .am_out    (am_out),
      .ni_out    (ni_out),
      .wce_out   (wce_out),
      .wme1_out  (wme1_out),
      .wme2_out  (wme2_out),
      .srcA_out  (srcA_out),
      .srcB_out  (srcB_out)
   );

   task automatic apply(input logic [42:0] v);
      {wbs_in, mm_in, ALUop_in, wm_in, am_in, ni_in,
       wce_in, wme1_in, wme2_in, srcA_in, srcB_in} = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [42:0] expected);
      n_checks++;
      assert (obs === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      apply(V3);

      // Reset held for two edges with non-zero inputs
      tick();
      tick();
      check("reset_all_zero", V_ZERO);
      n_checks++;
      assert (ALUop_out === 3'b000 && srcA_out === 16'h0000 && srcB_out === 16'h0000) else begin
         n_fail++;
         $error("FAIL reset_fields: observed alu=%b a=%h b=%h expected 000/0000/0000",
                ALUop_out, srcA_out, srcB_out);
      end

      // Load 1: not visible until the next edge
      rst_n = 1'b1;
      apply(V1);
      #2;
      check("load1_before_edge", V_ZERO);
      tick();
      check("load1", V1);

      // Load 2 fully replaces Load 1
      apply(V2);
      tick();
      check("load2", V2);

      // Stall holds Load 1 contents for three edges
      apply(V1);
      tick();
      check("reload1", V1);
      stall = 1'b1;
      apply(V3);
      tick();
      check("stall_edge1", V1);
      tick();
      check("stall_edge2", V1);
      tick();
      check("stall_edge3", V1);
      stall = 1'b0;
      tick();
      check("stall_release", V3);

      // Flush overrides a simultaneous stall
      stall = 1'b1;
      flush = 1'b1;
      tick();
      check("flush_over_stall", V_ZERO);
      stall = 1'b0;
      flush = 1'b0;
      apply(V2);
      tick();
      check("after_flush_load", V2);

      // Flush alone
      flush = 1'b1;
      apply(V1);
      tick();
      check("flush_alone", V_ZERO);
      flush = 1'b0;
      tick();
      check("after_flush_alone", V1);

      // Reset wins over normal load with non-zero inputs
      apply(V3);
      rst_n = 1'b0;
      tick();
      check("reset_priority", V_ZERO);
      rst_n = 1'b1;
      tick();
      check("post_reset_load", V3);

      // Reset pulsed between edges has no effect
      apply(V1);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      check("rst_pulse_no_async", V3);
      tick();
      check("rst_pulse_then_load", V1);

      // Reset during stall clears; stall then holds the cleared value
      stall = 1'b1;
      apply(V2);
      rst_n = 1'b0;
      tick();
      check("reset_in_stall", V_ZERO);
      rst_n = 1'b1;
      tick();
      check("stall_holds_cleared", V_ZERO);
      stall = 1'b0;
      tick();
      check("resume_after_stall", V2);

      // Reset has priority over flush and stall together
      flush = 1'b1;
      stall = 1'b1;
      rst_n = 1'b0;
      tick();
      check("reset_over_flush_stall", V_ZERO);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
